// File: rtl/mmreg_bank.sv
// Parametrised memory-mapped register bank with RW / RO / W1C registers, ack handshake and irq.
// Define MMREG_BANK_ERR_EN to add the reg_err port (out-of-range access and RO-write reporting).
module mmreg_bank #(
  parameter int unsigned         REG_DW   = 32,
  parameter int unsigned         REG_AW   = 8,
  parameter int unsigned         NUM_REGS = 16,
  parameter logic [NUM_REGS-1:0] RO_MASK  = '0,
  parameter logic [NUM_REGS-1:0] W1C_MASK = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       reg_req,
  input  logic                       reg_wr,
  input  logic [REG_AW-1:0]          reg_addr,
  input  logic [REG_DW-1:0]          reg_wdata,
  output logic [REG_DW-1:0]          reg_rdata,
  output logic                       reg_ack,
`ifdef MMREG_BANK_ERR_EN
  output logic                       reg_err,
`endif
  input  logic [NUM_REGS*REG_DW-1:0] ro_in,
  input  logic [NUM_REGS*REG_DW-1:0] hw_set,
  output logic [NUM_REGS*REG_DW-1:0] reg_q,
  output logic                       irq
);

  typedef enum logic [1:0] {IDLE, ACK, WAIT} state_t;

  state_t              state, state_nxt;
  logic                accept_c;
  logic                in_range_c;
  logic                ro_hit_c;
  logic                irq_c;
  logic [REG_DW-1:0]   rd_val_c;
  logic [NUM_REGS-1:0] wr_sel_c;
  logic [REG_DW-1:0]   regs [NUM_REGS];

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; WAIT blocks a held request from being accepted twice
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (reg_req) state_nxt = ACK;
      ACK:     state_nxt = reg_req ? WAIT : IDLE;
      WAIT:    if (!reg_req) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM output decode
  always_comb begin
    accept_c = 1'b0;
    if (state == IDLE && reg_req) accept_c = 1'b1;
  end

  // Address decode and read mux
  always_comb begin
    in_range_c = 32'(reg_addr) < NUM_REGS;
    ro_hit_c   = 1'b0;
    rd_val_c   = '0;
    wr_sel_c   = '0;
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      if (32'(reg_addr) == 32'(i)) begin
        wr_sel_c[i] = accept_c && reg_wr;
        if (RO_MASK[i]) begin
          ro_hit_c = 1'b1;
          rd_val_c = ro_in[i*REG_DW +: REG_DW];
        end else begin
          rd_val_c = regs[i];
        end
      end
    end
  end

  // Register storage; W1C bits absorb hw_set every cycle and a set beats a same-edge clear
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_REGS); i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        if (RO_MASK[i])
          regs[i] <= '0;
        else if (W1C_MASK[i])
          regs[i] <= (regs[i] & ~(wr_sel_c[i] ? reg_wdata : '0)) | hw_set[i*REG_DW +: REG_DW];
        else if (wr_sel_c[i])
          regs[i] <= reg_wdata;
      end
    end
  end

  // Register contents export and interrupt source
  always_comb begin
    reg_q = '0;
    irq_c = 1'b0;
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      reg_q[i*REG_DW +: REG_DW] = regs[i];
      if (W1C_MASK[i]) irq_c = irq_c | (|regs[i]);
    end
  end

  // Bus response and interrupt registers
  always_ff @(posedge clk) begin
    if (rst) begin
      reg_ack   <= 1'b0;
      reg_rdata <= '0;
      irq       <= 1'b0;
    end else begin
      reg_ack <= accept_c;
      irq     <= irq_c;
      if (accept_c && !reg_wr) reg_rdata <= rd_val_c;
    end
  end

  logic unused_ok;
`ifdef MMREG_BANK_ERR_EN
  always_ff @(posedge clk) begin
    if (rst) reg_err <= 1'b0;
    else     reg_err <= accept_c && (!in_range_c || (reg_wr && ro_hit_c));
  end
  assign unused_ok = ^{hw_set, ro_in};
`else
  assign unused_ok = ^{hw_set, ro_in, in_range_c, ro_hit_c};
`endif

endmodule

// File: tb/tb_mmreg_bank.sv
// Self-checking bench for mmreg_bank: 4 registers (reg 2 RO, reg 3 W1C), directed plan plus random traffic.
// Compile with MMREG_BANK_ERR_EN defined to also check reg_err.
module tb_mmreg_bank;

  logic         clk;
  logic         rst;
  logic         reg_req;
  logic         reg_wr;
  logic [7:0]   reg_addr;
  logic [31:0]  reg_wdata;
  logic [31:0]  reg_rdata;
  logic         reg_ack;
`ifdef MMREG_BANK_ERR_EN
  logic         reg_err;
`endif
  logic [127:0] ro_in;
  logic [127:0] hw_set;
  logic [127:0] reg_q;
  logic         irq;

  int total = 0;
  int bad   = 0;

  // Reference model: stored register values and last read data
  logic [31:0] m [4];
  logic [31:0] last_rd;

  mmreg_bank #(
    .REG_DW(32), .REG_AW(8), .NUM_REGS(4),
    .RO_MASK(4'b0100), .W1C_MASK(4'b1000)
  ) dut (
    .clk(clk), .rst(rst), .reg_req(reg_req), .reg_wr(reg_wr),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_rdata(reg_rdata),
    .reg_ack(reg_ack),
`ifdef MMREG_BANK_ERR_EN
    .reg_err(reg_err),
`endif
    .ro_in(ro_in), .hw_set(hw_set), .reg_q(reg_q), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] exp_q();
    return {m[3], 32'h0, m[1], m[0]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m[i] = '0;
    last_rd = '0;
  endtask

  // One full transaction starting #1 after a clock edge with the DUT idle
  task automatic xact(input string tag, input logic wr, input logic [7:0] addr,
                      input logic [31:0] wd, input logic [31:0] hs3);
    int   a;
    logic exp_err;
    a = int'(addr);
    hw_set[95:0]   = {$urandom(), $urandom(), $urandom()};
    hw_set[127:96] = hs3;
    reg_req = 1'b1; reg_wr = wr; reg_addr = addr; reg_wdata = wd;
    if (!wr) last_rd = (a >= 4) ? 32'h0 : (a == 2) ? ro_in[95:64] : m[a];
    exp_err = (a >= 4) || (wr && a == 2);
    if (wr && a == 3) m[3] = m[3] & ~wd;
    else if (wr && a < 2) m[a] = wd;
    m[3] = m[3] | hs3;
    @(posedge clk); #1;
    check({tag, "_ack"}, 128'(reg_ack), 128'(1'b1));
    check({tag, "_rdata"}, 128'(reg_rdata), 128'(last_rd));
    check({tag, "_q"}, reg_q, exp_q());
`ifdef MMREG_BANK_ERR_EN
    check({tag, "_err"}, 128'(reg_err), 128'(exp_err));
`endif
    reg_req = 1'b0;
    hw_set[127:96] = '0;
    @(posedge clk); #1;
    check({tag, "_ack_low"}, 128'(reg_ack), 128'(1'b0));
    check({tag, "_irq"}, 128'(irq), 128'(m[3] != 0));
  endtask

  initial begin
    int acks;
    rst = 1'b1; reg_req = 1'b0; reg_wr = 1'b0; reg_addr = '0; reg_wdata = '0;
    ro_in = '0; hw_set = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_ack", 128'(reg_ack), 128'(1'b0));
    check("rst_rdata", 128'(reg_rdata), 128'(0));
    check("rst_q", reg_q, 128'(0));
    check("rst_irq", 128'(irq), 128'(1'b0));
`ifdef MMREG_BANK_ERR_EN
    check("rst_err", 128'(reg_err), 128'(1'b0));
`endif
    rst = 1'b0;
    @(posedge clk); #1;

    // RW write then read
    xact("rw_wr", 1'b1, 8'd0, 32'hDEADBEEF, 32'h0);
    xact("rw_rd", 1'b0, 8'd0, 32'h0, 32'h0);

    // RO register: write ignored, read returns ro_in
    ro_in[95:64] = 32'h12345678;
    xact("ro_wr", 1'b1, 8'd2, 32'hFFFFFFFF, 32'h0);
    xact("ro_rd", 1'b0, 8'd2, 32'h0, 32'h0);

    // W1C: hw_set pulse, irq two cycles later
    hw_set[127:96] = 32'h5;
    @(posedge clk); #1;
    hw_set[127:96] = 32'h0;
    m[3] = m[3] | 32'h5;
    check("w1c_set_q", reg_q, exp_q());
    check("w1c_set_irq_early", 128'(irq), 128'(1'b0));
    @(posedge clk); #1;
    check("w1c_set_irq", 128'(irq), 128'(1'b1));
    xact("w1c_clr1", 1'b1, 8'd3, 32'h1, 32'h0);
    check("w1c_clr1_val", 128'(reg_q[127:96]), 128'(32'h4));
    xact("w1c_clr4", 1'b1, 8'd3, 32'h4, 32'h0);
    check("w1c_clr4_val", 128'(reg_q[127:96]), 128'(32'h0));

    // W1C collision: set wins over clear
    xact("w1c_coll", 1'b1, 8'd3, 32'h1, 32'h1);
    check("w1c_coll_val", 128'(reg_q[127:96]), 128'(32'h1));

    // Held request yields exactly one ack
    xact("rw1_wr", 1'b1, 8'd1, 32'hCAFE0001, 32'h0);
    acks = 0;
    reg_req = 1'b1; reg_wr = 1'b0; reg_addr = 8'd1;
    last_rd = m[1];
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      if (reg_ack) acks++;
      if (k == 0) check("held_rdata", 128'(reg_rdata), 128'(last_rd));
    end
    reg_req = 1'b0;
    @(posedge clk); #1;
    if (reg_ack) acks++;
    check("held_acks", 128'(acks), 128'(1));

    // Out of range read
    xact("oor_rd", 1'b0, 8'd7, 32'h0, 32'h0);
    xact("oor_wr", 1'b1, 8'd9, 32'h55AA55AA, 32'h0);

    // Reset in the cycle after a write is accepted
    reg_req = 1'b1; reg_wr = 1'b1; reg_addr = 8'd0; reg_wdata = 32'hA5A5A5A5;
    @(posedge clk); #1;
    rst = 1'b1; reg_req = 1'b0;
    @(posedge clk); #1;
    model_reset();
    check("mid_rst_q", reg_q, 128'(0));
    check("mid_rst_ack", 128'(reg_ack), 128'(1'b0));
    check("mid_rst_irq", 128'(irq), 128'(1'b0));
    rst = 1'b0;
    @(posedge clk); #1;
    xact("post_rst_rd", 1'b0, 8'd0, 32'h0, 32'h0);
    xact("post_rst_wr", 1'b1, 8'd1, 32'h13579BDF, 32'h0);

    // Random traffic against the model
    for (int n = 0; n < 40; n++) begin
      ro_in = {$urandom(), $urandom(), $urandom(), $urandom()};
      xact("rand", 1'($urandom_range(0, 1)), 8'($urandom_range(0, 7)), $urandom(),
           ($urandom_range(0, 1) == 1) ? $urandom() : 32'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mmreg_bank.md
# mmreg_bank

Parametrised memory-mapped register bank on the team's `reg_bus` request/data interface. It is the successor to the fixed dummy register target and adds:
- configurable register count;
- per-register access mode (read-write, read-only from hardware, write-1-to-clear status);
- an explicit `reg_ack` handshake;
- an interrupt output.

It sits behind the system register bus master and exports register contents to, and takes status from, the surrounding datapath.

## Interface
- `REG_DW`, 32, data width in bits.
- `REG_AW`, 8, word address width; the register index is `reg_addr` directly.
- `NUM_REGS`, 16, number of registers, 1..2^`REG_AW`.
- `RO_MASK`, 0, `NUM_REGS`-bit mask; bit i=1 makes register i read-only.
- `W1C_MASK`, 0, `NUM_REGS`-bit mask; bit i=1 makes register i write-1-to-clear. If `RO_MASK` and `W1C_MASK` are both set for a register, `RO_MASK` takes precedence.
- `clk` in 1: clock, all logic rising-edge.
- `rst` in 1: synchronous, active-high reset.
- `reg_req` in 1: request; held high with address/data stable until `reg_ack` is seen.
- `reg_wr` in 1: 1 = write, 0 = read.
- `reg_addr` in `REG_AW`: word address.
- `reg_wdata` in `REG_DW`: write data.
- `reg_rdata` out `REG_DW`: read data, valid while `reg_ack`=1 for a read; held until the next read.
- `reg_ack` out 1: one-cycle completion pulse.
- `reg_err` out 1: address error, only with `MMREG_BANK_ERR_EN`.
- `ro_in` in `NUM_REGS*REG_DW`: hardware values for RO registers; slice i is register i.
- `hw_set` in `NUM_REGS*REG_DW`: per-bit set strobes for W1C registers.
- `reg_q` out `NUM_REGS*REG_DW`: current contents of all stored registers; RO slices drive 0.
- `irq` out 1: registered OR of all W1C register bits.

## Operation
- FSM states:
  - **IDLE**: if `reg_req`=1, accept the request and go to ACK.
  - **ACK**: `reg_ack`=1. Go to IDLE if `reg_req`=0, else go to WAIT.
  - **WAIT**: stay until `reg_req`=0, then go to IDLE. This prevents a held request from being accepted twice.
- Accept = the IDLE edge with `reg_req`=1. Address, data and `reg_wr` are sampled only at that edge.
- Write to an RW register: the register takes `reg_wdata` at the accept edge.
- Write to an RO register: ignored.
- Write to a W1C register: next = (cur & ~`reg_wdata`) | `hw_set` slice. On simultaneous set and clear of a bit, the set wins.
- W1C bits take their `hw_set` slice every cycle, independent of bus activity. RW registers ignore `hw_set`.
- Reads return:
  - RW/W1C registers: the stored value before any same-edge update;
  - RO registers: `ro_in` sampled at the accept edge.
  - `reg_rdata` is loaded at the accept edge.
- Address ≥ `NUM_REGS` (out of range): writes are ignored; reads return 0.
- Reset: all registers are 0, FSM goes to IDLE, and `reg_rdata`, `reg_ack`, `irq` and `reg_err` are all 0. Reset mid-transaction aborts the transaction with no ack. A write accepted at the reset edge is lost.

## Timing
- Latency: request sampled at edge N → `reg_ack`=1 for the cycle after edge N, with `reg_rdata` valid in that same cycle.
- Write effect: `reg_q` shows the new value in the cycle after edge N.
- Minimum spacing: two requests start ≥2 cycles apart (accept, ack, then IDLE). A back-to-back request is re-accepted only after `reg_req` has been seen low.
- `irq` is registered from the W1C register state, so it lags a W1C register change by one cycle. `irq` lags `hw_set` by 2 cycles.
- `reg_ack` is never high for two consecutive cycles.

## Configuration
- `MMREG_BANK_ERR_EN` defined:
  - `reg_err` port exists;
  - `reg_err`=1 together with `reg_ack` for an out-of-range access, or for a write to an RO register; 0 otherwise.
- Macro undefined:
  - no `reg_err` port;
  - out-of-range and RO-write accesses complete silently with a normal ack.

## Test plan
Bench parameters: `NUM_REGS`=4, `REG_DW`=32, `RO_MASK`=4'b0100, `W1C_MASK`=4'b1000.

- **RW write/read:** write 0xDEADBEEF to addr 0, then read addr 0 → `reg_ack` one cycle after each accept, `reg_rdata`=0xDEADBEEF, `reg_q[31:0]`=0xDEADBEEF.
- **RO read/write:** `ro_in` slice 2 = 0x12345678; write 0xFFFFFFFF to addr 2, then read addr 2 → `reg_rdata`=0x12345678; `reg_err`=1 on the write when `MMREG_BANK_ERR_EN` is defined.
- **W1C set/clear:**
  - pulse `hw_set` slice 3 = 0x5 → register 3 = 0x5, `irq`=1 two cycles after the pulse;
  - write 0x1 to addr 3 → register 3 = 0x4, `irq` stays 1;
  - write 0x4 to addr 3 → register 3 = 0, `irq`=0.
- **W1C collision:** at the accept edge of a write of 0x1 to addr 3, `hw_set` bit 0 = 1 → bit 0 remains 1.
- **Held request and out of range:** hold `reg_req` high for 5 cycles on a read of addr 1 → exactly one `reg_ack`. Read addr 7 → `reg_rdata`=0, with `reg_err`=1 if `MMREG_BANK_ERR_EN` is defined.
- **Reset mid-operation:** assert `rst` in the cycle after a write to addr 0 is accepted → addr 0 = 0, `reg_ack`=0, FSM in IDLE; a next request is accepted normally.
